// File: rtl/alert_event_logger.sv
// Security alert logger: a first-word fall-through FIFO of offending writes, with overflow
// accounting, per-module lock flags and a registered level interrupt.
module alert_event_logger #(
    parameter int DEPTH          = 8,
    parameter int LOCK_THRESHOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alertValid,
    input  logic [1:0] unauthorizedModuleID,
    input  logic [3:0] unauthorizedWriteAddress,
    input  logic [3:0] unauthorizedWriteData,
    input  logic       rdReady,
    output logic       rdValid,
    output logic [9:0] rdEntry,
    output logic [4:0] occupancy,
    output logic [1:0] fifoState,
    output logic [7:0] dropCount,
    output logic       overflowFlag,
    input  logic       overflowClear,
    output logic [3:0] moduleLocked,
    input  logic       clearLock,
    input  logic [1:0] clearModuleID,
    output logic       alertIrq
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [4:0]    DEPTH_C = 5'(DEPTH);
    localparam logic [3:0]    LOCK_C  = 4'(LOCK_THRESHOLD);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } fifo_state_e;

    fifo_state_e   state_q, state_d;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    occ_q, occ_d;
    logic [7:0]    drop_q, drop_d;
    logic          ovf_q, ovf_d;
    logic [3:0]    cnt_q [4];
    logic [3:0]    cnt_d [4];
    logic [3:0]    lock_q, lock_d;
    logic          irq_q, irq_d;
    logic          full_s, pop_s, push_s, drop_s;

    // FIFO pointer/occupancy and overflow bookkeeping
    always_comb begin
        full_s   = (occ_q == DEPTH_C);
        pop_s    = rdValid & rdReady;
        push_s   = alertValid & (~full_s | pop_s);
        drop_s   = alertValid & full_s & ~pop_s;
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 5'd1;
            2'b01:   occ_d = occ_q - 5'd1;
            default: occ_d = occ_q;
        endcase
        // A drop coinciding with a clear is still counted
        if (overflowClear) begin
            drop_d = drop_s ? 8'd1 : 8'd0;
        end else if (drop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (overflowClear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        irq_d = rdValid | ovf_q | (|lock_q);
    end

    // Per-module alert counters and locks; clearLock beats a same-cycle alert
    always_comb begin
        lock_d = lock_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clearLock && (clearModuleID == 2'(i))) begin
                cnt_d[i]  = 4'd0;
                lock_d[i] = 1'b0;
            end else if (alertValid && (unauthorizedModuleID == 2'(i)) && (cnt_q[i] != 4'hF)) begin
                cnt_d[i]  = cnt_q[i] + 4'd1;
                lock_d[i] = lock_q[i] | ((cnt_q[i] + 4'd1) >= LOCK_C);
            end else begin
                cnt_d[i]  = cnt_q[i];
                lock_d[i] = lock_q[i] | (cnt_q[i] >= LOCK_C);
            end
        end
    end

    // fifoState next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_s) begin
                    state_d = (occ_d == DEPTH_C) ? ST_FULL : ST_PARTIAL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_PARTIAL: begin
                if (occ_d == DEPTH_C) begin
                    state_d = ST_FULL;
                end else if (occ_d == 5'd0) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_PARTIAL;
                end
            end
            ST_FULL: begin
                if (pop_s && !push_s) begin
                    state_d = ST_PARTIAL;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= 5'd0;
            drop_q   <= 8'd0;
            ovf_q    <= 1'b0;
            lock_q   <= 4'd0;
            irq_q    <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= 4'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            lock_q   <= lock_d;
            irq_q    <= irq_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Entry storage; contents are meaningless while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= {unauthorizedModuleID, unauthorizedWriteAddress, unauthorizedWriteData};
        end
    end

    assign rdValid      = (occ_q != 5'd0);
    assign rdEntry      = mem_q[rd_ptr_q];
    assign occupancy    = occ_q;
    assign fifoState    = state_q;
    assign dropCount    = drop_q;
    assign overflowFlag = ovf_q;
    assign moduleLocked = lock_q;
    assign alertIrq     = irq_q;

endmodule

// File: tb/tb_alert_event_logger.sv
// Self-checking bench for alert_event_logger: directed scenarios followed by random traffic,
// compared each cycle against a queue-based reference model.
module tb_alert_event_logger;

    localparam int DEPTH = 8;
    localparam int TH    = 4;

    logic       clk = 1'b0;
    logic       rst, av, rr, oc, cl;
    logic [1:0] id, cid;
    logic [3:0] ad, dt;
    logic       rdValid, overflowFlag, alertIrq;
    logic [9:0] rdEntry;
    logic [4:0] occupancy;
    logic [1:0] fifoState;
    logic [7:0] dropCount;
    logic [3:0] moduleLocked;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [9:0] m_q[$];
    int         m_dc;
    bit         m_ovf;
    int         m_cnt[4];
    logic [3:0] m_lock;
    bit         m_irq;

    alert_event_logger #(.DEPTH(DEPTH), .LOCK_THRESHOLD(TH)) dut (
        .clk(clk), .rst(rst), .alertValid(av), .unauthorizedModuleID(id),
        .unauthorizedWriteAddress(ad), .unauthorizedWriteData(dt), .rdReady(rr),
        .rdValid(rdValid), .rdEntry(rdEntry), .occupancy(occupancy), .fifoState(fifoState),
        .dropCount(dropCount), .overflowFlag(overflowFlag), .overflowClear(oc),
        .moduleLocked(moduleLocked), .clearLock(cl), .clearModuleID(cid), .alertIrq(alertIrq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit full, valid, pop, drop;
        full  = (m_q.size() == DEPTH);
        valid = (m_q.size() != 0);
        if (rst) begin
            m_q.delete();
            m_dc = 0; m_ovf = 0; m_lock = 4'd0; m_irq = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            m_irq = valid || m_ovf || (m_lock != 4'd0);
            pop  = valid && rr;
            drop = av && full && !pop;
            if (pop) void'(m_q.pop_front());
            if (av && !drop) m_q.push_back({id, ad, dt});
            if (oc) m_dc = drop ? 1 : 0;
            else if (drop) m_dc = (m_dc == 255) ? 255 : m_dc + 1;
            if (drop) m_ovf = 1;
            else if (oc) m_ovf = 0;
            for (int i = 0; i < 4; i++) begin
                if (cl && cid == 2'(i)) begin
                    m_cnt[i] = 0; m_lock[i] = 1'b0;
                end else if (av && id == 2'(i)) begin
                    m_cnt[i] = (m_cnt[i] == 15) ? 15 : m_cnt[i] + 1;
                end
                if (m_cnt[i] >= TH) m_lock[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0] es;
        es = (m_q.size() == 0) ? 2'b00 : ((m_q.size() == DEPTH) ? 2'b10 : 2'b01);
        chk("rdValid", 16'(rdValid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) chk("rdEntry", 16'(rdEntry), 16'(m_q[0]));
        chk("occupancy", 16'(occupancy), 16'(m_q.size()));
        chk("fifoState", 16'(fifoState), 16'(es));
        chk("dropCount", 16'(dropCount), 16'(m_dc));
        chk("overflowFlag", 16'(overflowFlag), 16'(m_ovf));
        chk("moduleLocked", 16'(moduleLocked), 16'(m_lock));
        chk("alertIrq", 16'(alertIrq), 16'(m_irq));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic a, input logic [1:0] i, input logic [3:0] adv, input logic [3:0] dtv,
                          input logic r, input logic o, input logic c, input logic [1:0] ci);
        av = a; id = i; ad = adv; dt = dtv; rr = r; oc = o; cl = c; cid = ci;
    endtask

    task automatic alert(input logic [1:0] i, input logic [3:0] adv, input logic [3:0] dtv, input logic r);
        set_in(1'b1, i, adv, dtv, r, 1'b0, 1'b0, 2'd0);
        cycle();
    endtask

    task automatic idle(input logic r);
        set_in(1'b0, 2'd0, 4'd0, 4'd0, r, 1'b0, 1'b0, 2'd0);
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        idle(1'b0);
        idle(1'b0);
        chk("reset_occ", 16'(occupancy), 16'd0);
        chk("reset_irq", 16'(alertIrq), 16'd0);
        rst = 1'b0;

        // Single alert, first-word fall-through and irq latency
        alert(2'd2, 4'hA, 4'h5, 1'b0);
        chk("single_entry", 16'(rdEntry), 16'h02A5);
        chk("single_state", 16'(fifoState), 16'd1);
        chk("single_irq_lag", 16'(alertIrq), 16'd0);
        idle(1'b0);
        chk("single_irq", 16'(alertIrq), 16'd1);
        idle(1'b1);
        chk("single_drained", 16'(rdValid), 16'd0);

        // Overfill by one, then push+pop while full, then drain in order
        do_reset();
        for (int k = 0; k < 9; k++) alert(2'(k), 4'(k), 4'(15 - k), 1'b0);
        chk("full_occ", 16'(occupancy), 16'd8);
        chk("full_state", 16'(fifoState), 16'd2);
        chk("full_drop", 16'(dropCount), 16'd1);
        chk("full_ovf", 16'(overflowFlag), 16'd1);
        alert(2'd0, 4'hF, 4'hF, 1'b1);
        chk("full_pushpop_occ", 16'(occupancy), 16'd8);
        chk("full_pushpop_drop", 16'(dropCount), 16'd1);
        chk("full_pushpop_head", 16'(rdEntry), 16'h011E);
        for (int k = 0; k < 8; k++) idle(1'b1);
        chk("drained_state", 16'(fifoState), 16'd0);

        // overflowClear coincident with a drop, then alone
        for (int k = 0; k < 8; k++) alert(2'd3, 4'(k), 4'(k), 1'b0);
        set_in(1'b1, 2'd3, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 2'd0);
        cycle();
        chk("clr_drop_race_cnt", 16'(dropCount), 16'd1);
        chk("clr_drop_race_flag", 16'(overflowFlag), 16'd1);
        set_in(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0);
        cycle();
        chk("clr_cnt", 16'(dropCount), 16'd0);
        chk("clr_flag", 16'(overflowFlag), 16'd0);

        // dropCount saturation
        for (int k = 0; k < 260; k++) alert(2'(k), 4'hC, 4'h3, 1'b0);
        chk("drop_sat", 16'(dropCount), 16'd255);

        // Reset with three entries held and overflow set
        for (int k = 0; k < 5; k++) idle(1'b1);
        chk("pre_rst_occ", 16'(occupancy), 16'd3);
        do_reset();
        chk("rst_occ", 16'(occupancy), 16'd0);
        chk("rst_valid", 16'(rdValid), 16'd0);
        chk("rst_state", 16'(fifoState), 16'd0);
        chk("rst_drop", 16'(dropCount), 16'd0);
        chk("rst_irq", 16'(alertIrq), 16'd0);

        // Lock after threshold; clearLock beats a coincident alert
        for (int k = 0; k < 3; k++) alert(2'd1, 4'h4, 4'(k), 1'b0);
        chk("lock_before", 16'(moduleLocked), 16'd0);
        alert(2'd1, 4'h4, 4'h3, 1'b0);
        chk("lock_set", 16'(moduleLocked), 16'b0010);
        set_in(1'b1, 2'd1, 4'h4, 4'h4, 1'b0, 1'b0, 1'b1, 2'd1);
        cycle();
        chk("lock_clear", 16'(moduleLocked), 16'd0);
        chk("lock_clear_logged", 16'(occupancy), 16'd5);
        for (int k = 0; k < 3; k++) alert(2'd1, 4'h5, 4'(k), 1'b1);
        chk("lock_cnt_zeroed", 16'(moduleLocked), 16'd0);
        alert(2'd1, 4'h5, 4'h3, 1'b1);
        chk("lock_reset_again", 16'(moduleLocked), 16'b0010);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            set_in(1'($urandom_range(0, 99) < 60), 2'($urandom), 4'($urandom), 4'($urandom),
                   1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 4),
                   1'($urandom_range(0, 99) < 6), 2'($urandom));
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alert_event_logger.md
ALERT_EVENT_LOGGER -- requirements
Module: alert_event_logger

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count (power of two, 2..16).
REQ-002 Parameter LOCK_THRESHOLD, default 4, per-module alert count that sets a lock (1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 alertValid  input  1  one-cycle alert strobe from the upstream write monitor.
REQ-006 unauthorizedModuleID  input  2  offending module ID, valid with alertValid.
REQ-007 unauthorizedWriteAddress  input  4  offending address, valid with alertValid.
REQ-008 unauthorizedWriteData  input  4  offending data, valid with alertValid.
REQ-009 rdReady  input  1  consumer accepts the head entry.
REQ-010 rdValid  output  1  head entry available.
REQ-011 rdEntry  output  10  head entry, {moduleID[9:8], address[7:4], data[3:0]}.
REQ-012 occupancy  output  5  entries held, 0..DEPTH.
REQ-013 fifoState  output  2  00 EMPTY, 01 PARTIAL, 10 FULL.
REQ-014 dropCount  output  8  alerts lost to overflow, saturating.
REQ-015 overflowFlag  output  1  sticky; set on any drop.
REQ-016 overflowClear  input  1  pulse; clears overflowFlag and dropCount.
REQ-017 moduleLocked  output  4  per-module lock flags, bit i = module ID i.
REQ-018 clearLock  input  1  pulse; clears lock and counter of clearModuleID.
REQ-019 clearModuleID  input  2  module targeted by clearLock.
REQ-020 alertIrq  output  1  registered level interrupt.

Function
REQ-021 Push: alertValid=1 and (not full, or pop in the same cycle) SHALL write {ID,addr,data} at wrPtr; wrPtr increments modulo DEPTH.
REQ-022 Pop: rdValid=1 and rdReady=1 SHALL advance rdPtr modulo DEPTH; rdReady while rdValid=0 SHALL be ignored.
REQ-023 First-word fall-through: rdValid=(occupancy!=0); rdEntry SHALL be the oldest entry; a push into an empty FIFO SHALL appear on rdValid/rdEntry one cycle later.
REQ-024 Simultaneous push and pop SHALL leave occupancy unchanged; when full, both SHALL complete; when empty, only the push SHALL occur.
REQ-025 Drop: alertValid=1 while full and no pop SHALL discard the alert, increment dropCount (saturate at 255) and set overflowFlag.
REQ-026 overflowClear SHALL zero dropCount and overflowFlag next cycle; a drop in the same cycle SHALL win (dropCount=1, overflowFlag=1).
REQ-027 fifoState SHALL be a registered state machine: EMPTY->PARTIAL on push; PARTIAL->FULL when occupancy reaches DEPTH; FULL->PARTIAL on pop without push; PARTIAL->EMPTY when occupancy reaches 0; encoding 11 SHALL never occur.
REQ-028 Per-module 4-bit counters SHALL increment on every alertValid (accepted or dropped) for that ID, saturating at 15.
REQ-029 moduleLocked[i] SHALL set on the cycle the counter for module i becomes >= LOCK_THRESHOLD and stay set until clearLock for i.
REQ-030 clearLock SHALL zero counter i and moduleLocked[i] next cycle; an alertValid for the same ID in the same cycle SHALL still be logged but SHALL NOT increment the counter (clear wins).
REQ-031 alertIrq SHALL equal the registered OR of rdValid, overflowFlag and any moduleLocked bit, i.e. one cycle behind those flags.
REQ-032 Input fields SHALL be sampled only when alertValid=1; other inputs are don't-care.

Reset
REQ-033 rst=1 at a clock edge SHALL set pointers, occupancy, dropCount, counters to 0, fifoState=EMPTY, and rdValid, overflowFlag, moduleLocked, alertIrq to 0.
REQ-034 rst SHALL override any concurrent push, pop, overflowClear or clearLock; FIFO contents SHALL be discarded and rdEntry is don't-care while rdValid=0.
REQ-035 The first push SHALL be accepted on the first edge with rst=0.

Verification
REQ-036 Single alert ID=2, addr=0xA, data=0x5, rdReady=0 -> next cycle rdValid=1, rdEntry=0x2A5, occupancy=1, fifoState=01, alertIrq=1 one cycle later.
REQ-037 9 back-to-back alerts, rdReady=0, DEPTH=8 -> occupancy=8, fifoState=10, dropCount=1, overflowFlag=1; drain yields the first 8 entries in order.
REQ-038 Full FIFO, alertValid=1 and rdReady=1 same cycle -> occupancy stays 8, dropCount unchanged, new entry lands at tail.
REQ-039 4 alerts from ID=1 -> moduleLocked=0010 after the 4th; clearLock with clearModuleID=1 coincident with a 5th ID=1 alert -> moduleLocked=0000, counter=0, entry logged.
REQ-040 rst asserted with 3 entries and overflowFlag=1 -> next cycle occupancy=0, rdValid=0, fifoState=00, dropCount=0, alertIrq=0.
